// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with parallel load, cascadable terminal-count
// flag and a free-running digit scanner for a multiplexed decimal display.
module bcd_scan_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_b,
  input  logic                  Enable,
  input  logic                  Up_Down,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Load_Value,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  Carry_Out,
  output logic                  Load_Error,
  output logic [3:0]            BCD_Digit,
  output logic [DIGITS-1:0]     Digit_Select
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);
  localparam logic [15:0] PreMax = 16'(SCAN_DIV - 1);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                load_error_q, load_error_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [15:0]         prescale_q, prescale_d;

  logic load_ok;
  logic all_nine;
  logic all_zero;
  logic scan_advance;

  // Per-digit classification of the load word and the current count
  always_comb begin
    load_ok  = 1'b1;
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (Load_Value[4*i +: 4] > 4'd9) load_ok = 1'b0;
      if (count_q[4*i +: 4] != 4'd9)   all_nine = 1'b0;
      if (count_q[4*i +: 4] != 4'd0)   all_zero = 1'b0;
    end
  end

  assign Carry_Out = Enable & ~Load & (Up_Down ? all_nine : all_zero);

  // Next count: load has priority, then a decimal ripple step, else hold
  always_comb begin
    logic       ripple;
    logic [3:0] nib;
    count_d      = count_q;
    load_error_d = 1'b0;
    ripple       = 1'b1;
    nib          = 4'd0;
    if (Load) begin
      if (load_ok) count_d = Load_Value;
      else         load_error_d = 1'b1;
    end else if (Enable) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        nib = count_q[4*i +: 4];
        if (ripple) begin
          if (Up_Down) begin
            if (nib == 4'd9) begin
              count_d[4*i +: 4] = 4'd0;
            end else begin
              count_d[4*i +: 4] = nib + 4'd1;
              ripple = 1'b0;
            end
          end else begin
            if (nib == 4'd0) begin
              count_d[4*i +: 4] = 4'd9;
            end else begin
              count_d[4*i +: 4] = nib - 4'd1;
              ripple = 1'b0;
            end
          end
        end
      end
    end
  end

  // Count and load-error state
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      count_q      <= '0;
      load_error_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      load_error_q <= load_error_d;
    end
  end

  assign Count      = count_q;
  assign Load_Error = load_error_q;

  assign scan_advance = (prescale_q == PreMax);

  // Scanner next state; with DIGITS = 1 IdxMax is 0 so the index stays put
  always_comb begin
    prescale_d = prescale_q + 16'd1;
    idx_d      = idx_q;
    if (scan_advance) begin
      prescale_d = 16'd0;
      idx_d      = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Scanner state, free-running regardless of Enable and Load
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      prescale_q <= 16'd0;
      idx_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      idx_q      <= idx_d;
    end
  end

  // Digit mux and one-hot select, straight from registered index and count
  always_comb begin
    BCD_Digit    = 4'd0;
    Digit_Select = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        BCD_Digit       = count_q[4*i +: 4];
        Digit_Select[i] = 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  for (genvar gi = 0; gi < int'(DIGITS); gi++) begin : g_bcd_chk
    a_digit_bcd : assert property (@(posedge Clock) disable iff (!Reset_b)
                                   count_q[4*gi +: 4] <= 4'd9);
  end
`endif

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: a driver issues stimulus and pushes expected
// observations from a decimal-integer model; a monitor pops and compares them.
module tb_bcd_scan_counter;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 3;
  localparam int          MODULUS  = 10000;

  logic        Clock = 1'b0;
  logic        Reset_b = 1'b0;
  logic        Enable = 1'b0;
  logic        Up_Down = 1'b1;
  logic        Load = 1'b0;
  logic [15:0] Load_Value = 16'h0;
  logic [15:0] Count;
  logic        Carry_Out;
  logic        Load_Error;
  logic [3:0]  BCD_Digit;
  logic [3:0]  Digit_Select;

  bcd_scan_counter #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .Clock        (Clock),
    .Reset_b      (Reset_b),
    .Enable       (Enable),
    .Up_Down      (Up_Down),
    .Load         (Load),
    .Load_Value   (Load_Value),
    .Count        (Count),
    .Carry_Out    (Carry_Out),
    .Load_Error   (Load_Error),
    .BCD_Digit    (BCD_Digit),
    .Digit_Select (Digit_Select)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] count;
    logic        err;
    logic        carry;
    logic [3:0]  digit;
    logic [3:0]  sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: count as a plain decimal integer, edges since reset release
  int          m_n;
  bit          m_err;
  int          m_edges;
  bit          m_en, m_ud, m_ld;
  logic [15:0] m_lv;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int          v;
    v = n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    int r, w;
    r = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      r = r + int'(v[4*i +: 4]) * w;
      w = w * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_err = 0; m_edges = 0;
    m_en = 0; m_ud = 1; m_ld = 0; m_lv = '0;
  endtask

  // Apply the clock edge that just happened to the model
  task automatic model_step();
    m_edges++;
    m_err = 0;
    if (m_ld) begin
      if (bcd_ok(m_lv)) m_n = from_bcd(m_lv);
      else              m_err = 1;
    end else if (m_en) begin
      m_n = m_ud ? (m_n + 1) % MODULUS : (m_n + MODULUS - 1) % MODULUS;
    end
  endtask

  // One cycle: settle the model for the last edge, drive new inputs, push expectation
  task automatic cyc(input bit en, input bit ud, input bit ld, input logic [15:0] lv);
    exp_t e;
    int   idx, p;
    @(posedge Clock);
    #1;
    model_step();
    Enable = en; Up_Down = ud; Load = ld; Load_Value = lv;
    m_en = en; m_ud = ud; m_ld = ld; m_lv = lv;
    idx = (m_edges / SCAN_DIV) % DIGITS;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    e.count = to_bcd(m_n);
    e.err   = m_err;
    e.carry = en && !ld && (ud ? (m_n == MODULUS - 1) : (m_n == 0));
    e.digit = 4'((m_n / p) % 10);
    e.sel   = 4'(1 << idx);
    exp_q.push_back(e);
  endtask

  // Asynchronous reset between clock edges, checked immediately
  task automatic reset_mid();
    @(negedge Clock);
    #2;
    Reset_b = 1'b0;
    #1;
    chk("reset_count", 32'(Count), 32'h0);
    chk("reset_sel", 32'(Digit_Select), 32'h1);
    chk("reset_digit", 32'(BCD_Digit), 32'h0);
    chk("reset_err", 32'(Load_Error), 32'h0);
    Enable = 0; Load = 0; Up_Down = 1; Load_Value = '0;
    @(posedge Clock);
    @(negedge Clock);
    #2;
    Reset_b = 1'b1;
    model_reset();
  endtask

  // Monitor: every cycle the DUT presents a state; compare against the queue
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", 32'(Count), 32'(e.count));
      chk("load_error", 32'(Load_Error), 32'(e.err));
      chk("carry_out", 32'(Carry_Out), 32'(e.carry));
      chk("bcd_digit", 32'(BCD_Digit), 32'(e.digit));
      chk("digit_select", 32'(Digit_Select), 32'(e.sel));
    end
  end

  initial begin
    logic [15:0] lv;
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #2;
    Reset_b = 1'b1;

    // Count up 12 cycles, then reset mid-run
    repeat (12) cyc(1, 1, 0, 16'h0);
    cyc(0, 1, 0, 16'h0);
    chk("count_after_12", 32'(to_bcd(m_n)), 32'h0012);
    reset_mid();

    // Up through all-9s wrap
    cyc(0, 1, 1, 16'h9998);
    repeat (3) cyc(1, 1, 0, 16'h0);
    cyc(0, 1, 0, 16'h0);

    // Down through all-0s wrap
    cyc(0, 0, 1, 16'h0001);
    repeat (3) cyc(1, 0, 0, 16'h0);
    cyc(0, 0, 0, 16'h0);

    // Rejected load then good load
    cyc(0, 1, 1, 16'h0042);
    cyc(0, 1, 1, 16'h12A4);
    cyc(0, 1, 1, 16'h1234);
    cyc(0, 1, 0, 16'h0);

    // Load beats Enable
    cyc(1, 1, 1, 16'h0500);
    cyc(0, 1, 0, 16'h0);

    // Scanner walk over a fixed count
    cyc(0, 1, 1, 16'h4321);
    repeat (15) cyc(0, 1, 0, 16'h0);

    // Randomized traffic with one asynchronous reset in the middle
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) reset_mid();
      lv = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        for (int d = 0; d < 4; d++) lv[4*d +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 1) == 1) lv = (lv[0] ? 16'h9999 : 16'h0000);
      end
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 9) == 0), lv);
    end
    cyc(0, 1, 0, 16'h0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge Clock);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
